// File: rtl/mod_pattern_gen.sv
// Light-source modulation / pixel bucket-select generator for one exposure, gated on a settled PLL lock.
// Optional macro BUCKET_DEADTIME_EN adds a complementary BUCKET_SEL_N with one-clock dead time at each edge.
module mod_pattern_gen #(
    parameter int CNT_W          = 16,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int HALF_PERIOD_LO = 8,
    parameter int HALF_PERIOD_HI = 2
) (
    input  logic             CLK_IN,
    input  logic             RESET,
    input  logic             LOCKED,
    input  logic             FLAG_HIGH_FREQ,
    input  logic             ENABLE,
    input  logic [7:0]       PHASE_DELAY,
    input  logic [CNT_W-1:0] NUM_PERIODS,
    output logic             BUCKET_SEL,
    output logic             MOD_OUT,
    output logic             ACTIVE,
    output logic             EXPOSURE_DONE,
    output logic             FREQ_STATUS
`ifdef BUCKET_DEADTIME_EN
    ,output logic            BUCKET_SEL_N
`endif
);

    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] H_LO    = CNT_W'(HALF_PERIOD_LO);
    localparam logic [CNT_W-1:0] H_HI    = CNT_W'(HALF_PERIOD_HI);
    localparam logic [CNT_W-1:0] LAST_LO = CNT_W'(2 * HALF_PERIOD_LO - 1);
    localparam logic [CNT_W-1:0] LAST_HI = CNT_W'(2 * HALF_PERIOD_HI - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state, state_n;
    logic             lock_m, lock_s;
    logic             armed, armed_n;
    logic             hf_r, hf_r_n;
    logic [7:0]       d_r, d_r_n;
    logic [CNT_W-1:0] n_r, n_r_n;
    logic [ST_W-1:0]  settle_cnt, settle_cnt_n;
    logic [CNT_W-1:0] b_ph, b_ph_n, b_cnt, b_cnt_n;
    logic [CNT_W-1:0] m_ph, m_ph_n, m_cnt, m_cnt_n;
    logic [7:0]       dly, dly_n;
    logic [CNT_W-1:0] h_val, last_ph;
    logic             abort, run_n, act_n;
    logic             bucket_n, mod_n, done_n;
`ifdef BUCKET_DEADTIME_EN
    logic             bucket_nn;
`endif

    always_comb begin
        state_n      = state;
        armed_n      = armed;
        hf_r_n       = hf_r;
        d_r_n        = d_r;
        n_r_n        = n_r;
        settle_cnt_n = settle_cnt;
        b_ph_n       = b_ph;
        b_cnt_n      = b_cnt;
        m_ph_n       = m_ph;
        m_cnt_n      = m_cnt;
        dly_n        = dly;
        h_val        = hf_r ? H_HI : H_LO;
        last_ph      = hf_r ? LAST_HI : LAST_LO;
        abort        = !lock_s || !ENABLE || (FLAG_HIGH_FREQ != hf_r);

        case (state)
            ST_IDLE: begin
                if (lock_s && ENABLE && armed) begin
                    state_n      = ST_SETTLE;
                    hf_r_n       = FLAG_HIGH_FREQ;
                    d_r_n        = PHASE_DELAY;
                    n_r_n        = NUM_PERIODS;
                    settle_cnt_n = ST_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (!lock_s || !ENABLE) begin
                    state_n = ST_IDLE;
                end else if (settle_cnt == '0) begin
                    state_n = ST_RUN;
                    b_ph_n  = '0;
                    b_cnt_n = '0;
                    m_ph_n  = '0;
                    m_cnt_n = '0;
                    dly_n   = d_r;
                end else begin
                    settle_cnt_n = settle_cnt - 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else begin
                    b_ph_n  = (b_ph == last_ph) ? '0 : b_ph + 1'b1;
                    b_cnt_n = (b_ph == last_ph) ? b_cnt + 1'b1 : b_cnt;
                    // The mod waveform holds at phase 0 until the phase delay has elapsed.
                    if (dly != 8'd0) begin
                        dly_n = dly - 1'b1;
                    end else begin
                        m_ph_n  = (m_ph == last_ph) ? '0 : m_ph + 1'b1;
                        m_cnt_n = (m_ph == last_ph) ? m_cnt + 1'b1 : m_cnt;
                    end
                    if (n_r != '0) begin
                        if (state == ST_RUN && b_cnt_n == n_r) begin
                            state_n = (m_cnt_n == n_r) ? ST_DONE : ST_DRAIN;
                        end else if (state == ST_DRAIN && m_cnt_n == n_r) begin
                            state_n = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (state == ST_DONE) begin
            armed_n = 1'b0;
        end else if (!ENABLE) begin
            armed_n = 1'b1;
        end

        // Outputs are decoded from next-cycle values so the registers line up with the state.
        run_n    = (state_n == ST_RUN);
        act_n    = run_n || (state_n == ST_DRAIN);
        done_n   = (state_n == ST_DONE);
        mod_n    = act_n && (dly_n == 8'd0) && (m_ph_n < h_val);
`ifdef BUCKET_DEADTIME_EN
        bucket_n  = run_n && (b_ph_n < h_val) && (b_ph_n != '0);
        bucket_nn = run_n && (b_ph_n >= h_val) && (b_ph_n != h_val);
`else
        bucket_n  = run_n && (b_ph_n < h_val);
`endif
    end

    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            state         <= ST_IDLE;
            lock_m        <= 1'b0;
            lock_s        <= 1'b0;
            armed         <= 1'b1;
            hf_r          <= 1'b0;
            d_r           <= '0;
            n_r           <= '0;
            settle_cnt    <= '0;
            b_ph          <= '0;
            b_cnt         <= '0;
            m_ph          <= '0;
            m_cnt         <= '0;
            dly           <= '0;
            BUCKET_SEL    <= 1'b0;
            MOD_OUT       <= 1'b0;
            ACTIVE        <= 1'b0;
            EXPOSURE_DONE <= 1'b0;
            FREQ_STATUS   <= 1'b0;
`ifdef BUCKET_DEADTIME_EN
            BUCKET_SEL_N  <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            lock_m        <= LOCKED;
            lock_s        <= lock_m;
            armed         <= armed_n;
            hf_r          <= hf_r_n;
            d_r           <= d_r_n;
            n_r           <= n_r_n;
            settle_cnt    <= settle_cnt_n;
            b_ph          <= b_ph_n;
            b_cnt         <= b_cnt_n;
            m_ph          <= m_ph_n;
            m_cnt         <= m_cnt_n;
            dly           <= dly_n;
            BUCKET_SEL    <= bucket_n;
            MOD_OUT       <= mod_n;
            ACTIVE        <= act_n;
            EXPOSURE_DONE <= done_n;
            FREQ_STATUS   <= hf_r_n;
`ifdef BUCKET_DEADTIME_EN
            BUCKET_SEL_N  <= bucket_nn;
`endif
        end
    end

endmodule
